// File: rtl/count_arb_pkg.sv
// ============================================================================
// Module      : count_arb_pkg
// Description : Shared defaults and the rotated first-one search for
//               count_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_arb_pkg;

    localparam int   N_DEF   = 4;
    localparam int   W_DEF   = 4;
    localparam int   MAX_DEF = 15;
    localparam int   N_LIMIT = 32;
    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Returns the first set index of vec[n-1:0] starting at ptr and wrapping; n if none set.
    function automatic int rr_first(input logic [N_LIMIT-1:0] vec, input int n, input int ptr);
        int idx;
        rr_first = n;
        for (int k = N_LIMIT - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (vec[idx[4:0]]) begin
                    rr_first = idx;
                end
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin winner select over an eligibility vector; owns the
//               rotating priority pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import count_arb_pkg::*;
#(
    parameter  int N  = N_DEF,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_elig,
    input  logic          i_adv,
    output logic          o_win_vld,
    output logic [PW-1:0] o_win_idx
);

    logic [PW-1:0] r_ptr;
    int            w_first;

    always_comb begin
        w_first   = rr_first(N_LIMIT'(i_elig), N, int'(r_ptr));
        o_win_idx = '0;
        for (int j = 0; j < N; j++) begin
            if (w_first == j) begin
                o_win_idx = PW'(j);
            end
        end
    end

    assign o_win_vld = |i_elig;

    // The pointer moves past the winner only when the grant is actually applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_adv && o_win_vld) begin
            r_ptr <= (o_win_idx == PW'(N - 1)) ? '0 : o_win_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_arbiter.sv
// ============================================================================
// Module      : count_arbiter
// Description : Shared up/down occupancy counter with round-robin access for
//               N requesters. Define COUNT_ARB_WRAP_EN for wrap-around counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int W   = W_DEF,
    parameter int MAX = MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] dir,
    input  logic         clr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] count,
    output logic         empty,
    output logic         full,
    output logic         stall
);

    localparam int           PW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] C_MAX  = W'(MAX);
    localparam logic [W-1:0] C_ZERO = '0;

    logic [N-1:0]  w_pend;
    logic [N-1:0]  w_elig;
    logic          w_win_vld;
    logic [PW-1:0] w_win_idx;
    logic [N-1:0]  w_gnt_nxt;
    logic [W-1:0]  w_cnt_nxt;
    logic          w_stall_nxt;

    // A requester granted last cycle is masked so a held req is not granted twice.
    assign w_pend = req & ~gnt;

`ifdef COUNT_ARB_WRAP_EN
    assign w_elig      = w_pend;
    assign w_stall_nxt = 1'b0;
`else
    generate
        for (genvar i = 0; i < N; i++) begin : g_elig
            assign w_elig[i] = w_pend[i] &
                               ((dir[i] == DIR_INC) ? (count < C_MAX) : (count > C_ZERO));
        end
    endgenerate
    assign w_stall_nxt = ~w_win_vld & (|w_pend);
`endif

    rr_arbiter #(
        .N (N)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_elig    (w_elig),
        .i_adv     (~clr),
        .o_win_vld (w_win_vld),
        .o_win_idx (w_win_idx)
    );

    always_comb begin
        w_gnt_nxt = '0;
        w_cnt_nxt = count;
        if (clr) begin
            w_cnt_nxt = C_ZERO;
        end else if (w_win_vld) begin
            w_gnt_nxt[w_win_idx] = 1'b1;
            if (dir[w_win_idx] == DIR_INC) begin
                w_cnt_nxt = (count == C_MAX) ? C_ZERO : count + 1'b1;
            end else begin
                w_cnt_nxt = (count == C_ZERO) ? C_MAX : count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt   <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            stall <= 1'b0;
        end else begin
            gnt   <= w_gnt_nxt;
            count <= w_cnt_nxt;
            empty <= (w_cnt_nxt == C_ZERO);
            full  <= (w_cnt_nxt == C_MAX);
            stall <= w_stall_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_count_arbiter.sv
// ============================================================================
// Module      : tb_count_arbiter
// Description : Self-checking bench for count_arbiter against a behavioural
//               model; honours COUNT_ARB_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int MAX = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [N-1:0] req;
    logic [N-1:0] dir;
    logic [N-1:0] gnt;
    logic [W-1:0] count;
    logic         empty;
    logic         full;
    logic         stall;

    always #5 clk = ~clk;

    count_arbiter #(
        .N   (N),
        .W   (W),
        .MAX (MAX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dir   (dir),
        .clr   (clr),
        .gnt   (gnt),
        .count (count),
        .empty (empty),
        .full  (full),
        .stall (stall)
    );

    int           n_pass = 0;
    int           n_tot  = 0;
    bit           chk_en = 1'b0;
    int           m_cnt;
    int           m_ptr;
    logic [N-1:0] m_gnt;
    logic         m_stall;

    task automatic check(input string name, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic bit can_move(input int i);
`ifdef COUNT_ARB_WRAP_EN
        return 1'b1;
`else
        return dir[i] ? (m_cnt < MAX) : (m_cnt > 0);
`endif
    endfunction

    // Reference: applies one clock edge's worth of the arbitration rules.
    task automatic model_step();
        int           win;
        int           idx;
        logic [N-1:0] pend;
        if (rst) begin
            m_cnt = 0; m_ptr = 0; m_gnt = '0; m_stall = 1'b0;
            return;
        end
        pend = req & ~m_gnt;
        win  = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (win < 0 && pend[idx] && can_move(idx)) win = idx;
        end
`ifdef COUNT_ARB_WRAP_EN
        m_stall = 1'b0;
`else
        m_stall = (win < 0) && (pend != '0);
`endif
        m_gnt = '0;
        if (clr) begin
            m_cnt = 0;
        end else if (win >= 0) begin
            m_gnt[win] = 1'b1;
            m_cnt = dir[win] ? (m_cnt + 1) % (MAX + 1) : (m_cnt + MAX) % (MAX + 1);
            m_ptr = (win + 1) % N;
        end
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d, input logic c, input logic rs);
        req = r; dir = d; clr = c; rst = rs;
        @(posedge clk);
        model_step();
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt",   int'(gnt),   int'(m_gnt));
            check("count", int'(count), m_cnt);
            check("empty", int'(empty), (m_cnt == 0) ? 1 : 0);
            check("full",  int'(full),  (m_cnt == MAX) ? 1 : 0);
            check("stall", int'(stall), int'(m_stall));
        end
    end

    initial begin
        logic [N-1:0] pr;
        logic [N-1:0] pd;
        int           bias;
        req = '0; dir = '0; clr = 1'b0; rst = 1'b1;
        @(posedge clk);
        model_step();
        #2;
        cyc('0, '0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_gnt",   int'(gnt),   0);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full",  int'(full),  0);
        check("rst_stall", int'(stall), 0);

        // Two incrementers held: alternate grants because of masking.
        cyc(4'b0011, 4'b1111, 1'b0, 1'b0);
        check("alt1_gnt", int'(gnt), 1);  check("alt1_cnt", int'(count), 1);
        cyc(4'b0011, 4'b1111, 1'b0, 1'b0);
        check("alt2_gnt", int'(gnt), 2);  check("alt2_cnt", int'(count), 2);
        cyc(4'b0011, 4'b1111, 1'b0, 1'b0);
        check("alt3_gnt", int'(gnt), 1);  check("alt3_cnt", int'(count), 3);
        check("model_cnt3", m_cnt, 3);
        repeat (11) cyc(4'b0011, 4'b1111, 1'b0, 1'b0);
        check("to14_cnt", int'(count), 14);
        cyc(4'b1111, 4'b1111, 1'b0, 1'b0);
        check("top_cnt", int'(count), 15);
        check("top_full", int'(full), 1);
        check("top_onehot", $countones(gnt), 1);

`ifndef COUNT_ARB_WRAP_EN
        cyc(4'b1111, 4'b1111, 1'b0, 1'b0);
        check("full_stall", int'(stall), 1);
        check("full_gnt", int'(gnt), 0);
        check("model_stall", int'(m_stall), 1);

        cyc('0, '0, 1'b1, 1'b0);
        check("clr0_cnt", int'(count), 0);
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0);
        check("empty_stall", int'(stall), 1);
        check("empty_gnt", int'(gnt), 0);
        cyc(4'b1100, 4'b1000, 1'b0, 1'b0);
        check("r3_gnt", int'(gnt), 8);
        check("r3_cnt", int'(count), 1);
`else
        cyc('0, '0, 1'b1, 1'b0);
        cyc(4'b0001, 4'b0000, 1'b0, 1'b0);
        check("wrap_dn_cnt", int'(count), 15);
        check("wrap_dn_gnt", int'(gnt), 1);
        cyc('0, '0, 1'b0, 1'b0);
        cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
        check("wrap_up_cnt", int'(count), 0);
        check("wrap_up_gnt", int'(gnt), 1);
        check("wrap_stall", int'(stall), 0);
`endif

        // Clear beats a pending grant; ptr is not disturbed.
        cyc('0, '0, 1'b1, 1'b0);
        repeat (7) cyc(4'b0011, 4'b1111, 1'b0, 1'b0);
        check("to7_cnt", int'(count), 7);
        cyc(4'b0010, 4'b0010, 1'b1, 1'b0);
        check("clr_cnt", int'(count), 0);
        check("clr_gnt", int'(gnt), 0);
        cyc(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("postclr_gnt", int'(gnt), 2);
        check("postclr_cnt", int'(count), 1);

        // Reset during a grant cycle.
        cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
        check("pre_rst_gnt", int'(gnt), 1);
        cyc(4'b0001, 4'b0001, 1'b0, 1'b1);
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_cnt", int'(count), 0);
        check("mid_rst_empty", int'(empty), 1);
        cyc(4'b1111, 4'b1111, 1'b0, 1'b0);
        check("ptr0_gnt", int'(gnt), 1);

        // Randomised traffic, swinging the direction bias to reach both bounds.
        pr = '0; pd = '0;
        for (int t = 0; t < 3000; t++) begin
            bias = ((t / 200) % 2 == 1) ? 20 : 80;
            for (int i = 0; i < N; i++) begin
                if (!pr[i] || m_gnt[i]) begin
                    pr[i] = ($urandom_range(0, 99) < 55);
                    pd[i] = ($urandom_range(0, 99) < bias);
                end
            end
            cyc(pr, pd, ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
